// File: rtl/fp_scale_sequencer_if.sv
// Handshake bundle between the scale sequencer, its element streams and the float multiplier.
interface fp_scale_sequencer_if;
    localparam int unsigned DATA_W = 32;

    logic [DATA_W-1:0] in_data;
    logic              in_stb;
    logic              in_ack;

    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic              mul_a_stb;
    logic              mul_b_stb;
    logic              mul_a_ack;
    logic              mul_b_ack;
    logic [DATA_W-1:0] mul_z;
    logic              mul_z_stb;
    logic              mul_z_ack;

    logic [DATA_W-1:0] out_data;
    logic              out_stb;
    logic              out_ack;

    modport master (
        input  in_data, in_stb, mul_a_ack, mul_b_ack, mul_z, mul_z_stb, out_ack,
        output in_ack, mul_a, mul_b, mul_a_stb, mul_b_stb, mul_z_ack, out_data, out_stb
    );

    modport slave (
        output in_data, in_stb, mul_a_ack, mul_b_ack, mul_z, mul_z_stb, out_ack,
        input  in_ack, mul_a, mul_b, mul_a_stb, mul_b_stb, mul_z_ack, out_data, out_stb
    );
endinterface

// File: rtl/fp_scale_sequencer.sv
// Streams a run of LEN floats through an external multiplier, scaling each by one captured scalar.
module fp_scale_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          scale,
    input  logic [CNT_W-1:0]     len,
    output logic                 busy,
    output logic                 done,
    fp_scale_sequencer_if.master bus
);
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE, GET_X, SEND_A, SEND_B, GET_Z, PUT_Z, FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  scale_q, scale_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               in_ack_q, in_ack_d;
    logic               a_stb_q, a_stb_d;
    logic               b_stb_q, b_stb_d;
    logic               z_ack_q, z_ack_d;
    logic               out_stb_q, out_stb_d;
    logic [DATA_W-1:0]  mul_a_q, mul_a_d;
    logic [DATA_W-1:0]  mul_b_q, mul_b_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;

    logic in_xfer, a_xfer, b_xfer, z_xfer, out_xfer;

    assign in_xfer  = bus.in_stb    && in_ack_q;
    assign a_xfer   = bus.mul_a_ack && a_stb_q;
    assign b_xfer   = bus.mul_b_ack && b_stb_q;
    assign z_xfer   = bus.mul_z_stb && z_ack_q;
    assign out_xfer = bus.out_ack   && out_stb_q;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            scale_q    <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ack_q   <= 1'b0;
            a_stb_q    <= 1'b0;
            b_stb_q    <= 1'b0;
            z_ack_q    <= 1'b0;
            out_stb_q  <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            scale_q    <= scale_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ack_q   <= in_ack_d;
            a_stb_q    <= a_stb_d;
            b_stb_q    <= b_stb_d;
            z_ack_q    <= z_ack_d;
            out_stb_q  <= out_stb_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            out_data_q <= out_data_d;
        end
    end

    // Each handshake output is the registered decode of the current state, dropped on its own transfer.
    always_comb begin
        state_d    = state_q;
        scale_d    = scale_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        busy_d     = done_q ? 1'b0 : busy_q;
        done_d     = 1'b0;
        in_ack_d   = 1'b0;
        a_stb_d    = 1'b0;
        b_stb_d    = 1'b0;
        z_ack_d    = 1'b0;
        out_stb_d  = 1'b0;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        out_data_d = out_data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    scale_d = scale;
                    len_d   = len;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (len == '0) ? FINISH : GET_X;
                end
            end
            GET_X: begin
                in_ack_d = !in_xfer;
                if (in_xfer) begin
                    mul_b_d = bus.in_data;
                    mul_a_d = scale_q;
                    state_d = SEND_A;
                end
            end
            SEND_A: begin
                a_stb_d = !a_xfer;
                if (a_xfer) state_d = SEND_B;
            end
            SEND_B: begin
                b_stb_d = !b_xfer;
                if (b_xfer) state_d = GET_Z;
            end
            GET_Z: begin
                z_ack_d = !z_xfer;
                if (z_xfer) begin
                    out_data_d = bus.mul_z;
                    state_d    = PUT_Z;
                end
            end
            PUT_Z: begin
                out_stb_d = !out_xfer;
                if (out_xfer) begin
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? FINISH : GET_X;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.in_ack    = in_ack_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.mul_a_stb = a_stb_q;
    assign bus.mul_b_stb = b_stb_q;
    assign bus.mul_z_ack = z_ack_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_stb   = out_stb_q;
endmodule

// File: doc/fp_scale_sequencer.md
Name: fp_scale_sequencer

Overview:
- Initiator for the 32-bit IEEE-754 single-precision multiplier's stb/ack operand/result interface.
- Scales a run of LEN elements by one scalar, e.g. multiplying each exponential by 1/sum in the softmax normalisation stage.
- Upstream side: accepts elements over an stb/ack stream. Multiplier side: issues operand pairs and collects each product. Downstream side: emits scaled results over an stb/ack stream, then pulses done.

Parameters:
- CNT_W, 16, width of the length/element counter (max run length 2^CNT_W-1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- scale  in  32  float scalar; captured on accepted start.
- len  in  CNT_W  number of elements in the run; captured on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last result transfers downstream.
- in_data  in  32  upstream element.
- in_stb  in  1  upstream element valid.
- in_ack  out  1  block ready to take an element.
- mul_a  out  32  multiplier operand a (scale).
- mul_b  out  32  multiplier operand b (element).
- mul_a_stb  out  1  operand a valid.
- mul_b_stb  out  1  operand b valid.
- mul_a_ack  in  1  multiplier took a.
- mul_b_ack  in  1  multiplier took b.
- mul_z  in  32  multiplier product.
- mul_z_stb  in  1  product valid.
- mul_z_ack  out  1  block takes product.
- out_data  out  32  scaled result.
- out_stb  out  1  result valid.
- out_ack  in  1  downstream took result.

Behaviour:
- Handshake rule, all interfaces: a word transfers on a rising edge where stb and ack are both high.
  - stb holders keep data stable and stb high until the transfer occurs.
  - The block never drops its own stb before the transfer.
- Reset:
  - FSM goes to IDLE; counter goes to 0.
  - busy, done, in_ack, mul_a_stb, mul_b_stb, mul_z_ack and out_stb all go to 0.
  - mul_a, mul_b and out_data go to 0.
  - Reset mid-run abandons the run without emitting done. The multiplier shares rst, so no partial operand survives.
- FSM states: IDLE, GET_X, SEND_A, SEND_B, GET_Z, PUT_Z, FINISH.
- IDLE:
  - start=1 captures scale and len, sets busy=1 and clears the counter.
  - If len==0, go to FINISH; otherwise go to GET_X.
  - start in any other state is ignored.
- GET_X: in_ack=1. On transfer, register in_data into mul_b, load scale into mul_a, then go to SEND_A.
- SEND_A: mul_a_stb=1 until mul_a_ack=1, then go to SEND_B.
- SEND_B: mul_b_stb=1 until mul_b_ack=1, then go to GET_Z.
  - The a and b strobes are never high at the same time.
- GET_Z:
  - mul_z_ack=1. On transfer, register mul_z into out_data and go to PUT_Z.
  - Multiplier latency is unbounded; wait indefinitely.
- PUT_Z: out_stb=1 until out_ack=1. On transfer, increment the counter.
  - If counter+1==len, go to FINISH; otherwise go to GET_X.
- FINISH: done=1 for exactly one cycle, busy=0 from the next cycle, then go to IDLE.
- Outputs:
  - All handshake outputs are registered, so each is asserted starting the cycle after state entry.
  - Each handshake output deasserts the cycle after its transfer.
  - At most one element is in flight at a time; no buffering beyond one word per stage.
- Throughput: at least 5 cycles per element plus multiplier latency, with all partners acking immediately.
- Arithmetic: the block does no float math. Values, including NaN, inf, zero and sign, pass through bit-exact.
- Counter: compares against the captured len and never wraps within a run. A len change during a run has no effect.

Test Plan:
1. rst held 2 cycles, then released.
   - All outputs must be 0, state IDLE.
   - in_stb=1 must not be acked.
2. start, scale=0x3f000000 (0.5), len=3, elements 0x40000000, 0x3f800000, 0x00000000, all partners acking immediately (real multiplier).
   - out_data must be 0x3f800000, 0x3f000000, 0x00000000 in order.
   - Exactly 3 out transfers, then one done pulse, busy=0.
3. scale=0xbf000000 (-0.5), len=1, element 0x3f000000.
   - out_data must be 0xbe800000.
   - mul_a/mul_b must be held stable while their stb is high.
4. Backpressure: multiplier model with random 0-7 cycle ack/stb delays, plus out_ack low for 5 cycles at each result, len=4.
   - No strobe may drop early and no result may be duplicated or lost.
   - Results must come in order and done must pulse once.
5. start with len=0 → done pulses 2 cycles after start, with no in_ack, mul_*_stb or out_stb activity.
6. rst asserted while in GET_Z mid-run.
   - Must return to IDLE, with no done and all stb/ack outputs low next cycle.
   - A fresh start, scale=0x3f000000, len=1, element 0x40000000, must give out_data 0x3f800000.
